// File: rtl/uart_frame_loader_if.sv
// Byte-stream and frame-buffer write signals between uart_frame_loader, uart_rx and the frame RAM.
// Handshake: rx_dv and mem_we are one-cycle strobes qualifying rx_byte and mem_addr/mem_data. There is no backpressure.
interface uart_frame_loader_if #(
    parameter int ADDR_W = 16
);
    logic              receive;
    logic              rx_dv;
    logic [7:0]        rx_byte;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;

    modport master (
        output receive, mem_we, mem_addr, mem_data,
        input  rx_dv, rx_byte
    );

    modport slave (
        input  receive, mem_we, mem_addr, mem_data,
        output rx_dv, rx_byte
    );
endinterface

// File: rtl/uart_frame_loader.sv
// Loads one frame (4-byte width/height header + pixels) from uart_rx into the frame buffer.
// Optional trailing XOR checksum byte when RX_CHECKSUM_EN is defined.
module uart_frame_loader #(
    parameter int ADDR_W       = 16,
    parameter int TIMEOUT_CLKS = 8680
) (
    input  logic                i_Clock,
    input  logic                reset,
    input  logic                i_start,
    uart_frame_loader_if.master bus,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error,
    output logic [15:0]         o_width,
    output logic [15:0]         o_height,
    output logic [2:0]          o_state
);
    localparam int          TMO_W   = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [32:0] MAX_PIX = 33'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_CHECK = 3'd2,
        S_PIX   = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5,
        S_CSUM  = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        hdr_idx_q, hdr_idx_d;
    logic [15:0]       width_q, width_d;
    logic [15:0]       height_q, height_d;
    logic [31:0]       total_q, total_d;
    logic [31:0]       pix_cnt_q, pix_cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              error_q, error_d;
    logic [7:0]        csum_q, csum_d;
    logic [31:0]       product;
    logic              tmo_done;

    assign product  = 32'(width_q) * 32'(height_q);
    assign tmo_done = (tmo_q == TMO_W'(TIMEOUT_CLKS - 1));

    always_ff @(posedge i_Clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            hdr_idx_q <= '0;
            width_q   <= '0;
            height_q  <= '0;
            total_q   <= '0;
            pix_cnt_q <= '0;
            tmo_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            error_q   <= 1'b0;
            csum_q    <= '0;
        end else begin
            state_q   <= state_d;
            hdr_idx_q <= hdr_idx_d;
            width_q   <= width_d;
            height_q  <= height_d;
            total_q   <= total_d;
            pix_cnt_q <= pix_cnt_d;
            tmo_q     <= tmo_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            error_q   <= error_d;
            csum_q    <= csum_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hdr_idx_d = hdr_idx_q;
        width_d   = width_q;
        height_d  = height_q;
        total_d   = total_q;
        pix_cnt_d = pix_cnt_q;
        tmo_d     = tmo_q + TMO_W'(1);
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        error_d   = error_q;
        csum_d    = csum_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d   = S_HDR;
                    error_d   = 1'b0;
                    hdr_idx_d = '0;
                    csum_d    = '0;
                end
            end
            S_HDR: begin
                if (bus.rx_dv) begin
                    tmo_d     = '0;
                    csum_d    = csum_q ^ bus.rx_byte;
                    hdr_idx_d = hdr_idx_q + 2'd1;
                    case (hdr_idx_q)
                        2'd0: width_d[7:0]   = bus.rx_byte;
                        2'd1: width_d[15:8]  = bus.rx_byte;
                        2'd2: height_d[7:0]  = bus.rx_byte;
                        default: height_d[15:8] = bus.rx_byte;
                    endcase
                    if (hdr_idx_q == 2'd3) state_d = S_CHECK;
                end else if (tmo_done) begin
                    state_d = S_ERR;
                end
            end
            S_CHECK: begin
                if (product == '0 || {1'b0, product} > MAX_PIX) begin
                    state_d = S_ERR;
                end else begin
                    state_d   = S_PIX;
                    total_d   = product;
                    pix_cnt_d = '0;
                end
            end
            S_PIX: begin
                // Bytes beyond the pixel count are dropped while the final write drains.
                if (bus.rx_dv && pix_cnt_q != total_q) begin
                    tmo_d     = '0;
                    we_d      = 1'b1;
                    addr_d    = pix_cnt_q[ADDR_W-1:0];
                    data_d    = bus.rx_byte;
                    pix_cnt_d = pix_cnt_q + 32'd1;
                    csum_d    = csum_q ^ bus.rx_byte;
                end else if (we_q && pix_cnt_q == total_q) begin
`ifdef RX_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_DONE;
`endif
                end else if (tmo_done) begin
                    state_d = S_ERR;
                end
            end
`ifdef RX_CHECKSUM_EN
            S_CSUM: begin
                if (bus.rx_dv) begin
                    tmo_d   = '0;
                    state_d = (bus.rx_byte == csum_q) ? S_DONE : S_ERR;
                end else if (tmo_done) begin
                    state_d = S_ERR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_ERR) error_d = 1'b1;
        // The idle timer restarts on every state entry and is parked outside the receiving states.
        if (state_d != state_q || !(state_q == S_HDR || state_q == S_PIX || state_q == S_CSUM)) tmo_d = '0;
    end

    assign bus.receive  = (state_q == S_HDR) || (state_q == S_PIX) || (state_q == S_CSUM);
    assign bus.mem_we   = we_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_data = data_q;
    assign o_busy       = (state_q != S_IDLE);
    assign o_done       = (state_q == S_DONE);
    assign o_error      = error_q;
    assign o_width      = width_q;
    assign o_height     = height_q;
    assign o_state      = state_q;
endmodule
